// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolutional encoder and the
// matching Viterbi decoder, so both ends agree on the generator polynomials.
// Optional build macro: CONV_ENC_TAIL_EN (adds the zero-tail states).
package conv_pkg;

  localparam int unsigned      CONV_K  = 7;
  localparam logic [CONV_K-1:0] CONV_G0 = 7'o171;
  localparam logic [CONV_K-1:0] CONV_G1 = 7'o133;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EMIT0 = 3'd1,
`ifdef CONV_ENC_TAIL_EN
    ST_EMIT1 = 3'd2,
    ST_TAIL0 = 3'd3,
    ST_TAIL1 = 3'd4
`else
    ST_EMIT1 = 3'd2
`endif
  } conv_enc_state_t;

endpackage

// File: rtl/conv_branch_out.sv
// Branch output of a rate-1/2 convolutional code: parity of the branch word
// masked by each generator. Shared by the encoder and the decoder metrics.
module conv_branch_out
  import conv_pkg::*;
#(
  parameter int unsigned K = CONV_K
) (
  input  logic [K-1:0] i_w,
  input  logic [K-1:0] i_g0,
  input  logic [K-1:0] i_g1,
  output logic [1:0]   o_c
);

  // {c0, c1} as the XOR-reduction of the tapped branch word
  always_comb begin
    o_c = {^(i_w & i_g0), ^(i_w & i_g1)};
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder. Accepts one information bit
// in IDLE, then serialises c0 and c1 on a valid/ready symbol stream.
// Build macro CONV_ENC_TAIL_EN: append K-1 zero tail bits after each frame so
// the encoder state returns to zero; otherwise the state is cleared on the
// last symbol of the frame.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int unsigned  K  = CONV_K,
  parameter logic [K-1:0] G0 = CONV_G0,
  parameter logic [K-1:0] G1 = CONV_G1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic sym_bit,
  output logic sym_valid,
  input  logic sym_ready,
  output logic sym_last
);

  conv_enc_state_t r_state;
  conv_enc_state_t w_state_nxt;

  logic [K-2:0] r_sr;
  logic         r_c1;
  logic         r_last;
  logic         r_sym_bit;
  logic         r_sym_valid;
  logic         r_sym_last;

  logic         w_b;
  logic [K-1:0] w_w;
  logic [1:0]   w_c;

`ifdef CONV_ENC_TAIL_EN
  localparam int unsigned TW = $clog2(K);
  logic [TW-1:0] r_tcnt;
  logic          w_tcnt_done;

  assign w_tcnt_done = (r_tcnt == TW'(K - 2));
`endif

  // Input bit is only taken in IDLE; every tail branch shifts in a zero.
  assign w_b = in_bit & (r_state == ST_IDLE);
  assign w_w = {w_b, r_sr};

  conv_branch_out #(
    .K (K)
  ) u_branch (
    .i_w  (w_w),
    .i_g0 (G0),
    .i_g1 (G1),
    .o_c  (w_c)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign sym_bit   = r_sym_bit;
  assign sym_valid = r_sym_valid;
  assign sym_last  = r_sym_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: advance on input accept or symbol handshake
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (in_valid)  w_state_nxt = ST_EMIT0;
      ST_EMIT0: if (sym_ready) w_state_nxt = ST_EMIT1;
      ST_EMIT1: begin
        if (sym_ready) begin
`ifdef CONV_ENC_TAIL_EN
          w_state_nxt = r_last ? ST_TAIL0 : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef CONV_ENC_TAIL_EN
      ST_TAIL0: if (sym_ready) w_state_nxt = ST_TAIL1;
      ST_TAIL1: if (sym_ready) w_state_nxt = w_tcnt_done ? ST_IDLE : ST_TAIL0;
`endif
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: shift register, latched c1, and the registered symbol outputs.
  // The branch is evaluated when a bit is loaded (input accept or tail entry),
  // so c0 is on the stream the very next cycle and c1 waits in r_c1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr        <= '0;
      r_c1        <= 1'b0;
      r_last      <= 1'b0;
      r_sym_bit   <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_last  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      r_tcnt      <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sym_bit   <= w_c[1];
            r_c1        <= w_c[0];
            r_sr        <= {w_b, r_sr[K-2:1]};
            r_last      <= in_last;
            r_sym_valid <= 1'b1;
            r_sym_last  <= 1'b0;
          end
        end
        ST_EMIT0: begin
          if (sym_ready) begin
            r_sym_bit <= r_c1;
`ifdef CONV_ENC_TAIL_EN
            r_sym_last <= 1'b0;
`else
            r_sym_last <= r_last;
`endif
          end
        end
        ST_EMIT1: begin
          if (sym_ready) begin
`ifdef CONV_ENC_TAIL_EN
            if (r_last) begin
              r_sym_bit <= w_c[1];
              r_c1      <= w_c[0];
              r_sr      <= {w_b, r_sr[K-2:1]};
              r_tcnt    <= '0;
            end else begin
              r_sym_valid <= 1'b0;
              r_sym_last  <= 1'b0;
            end
`else
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
            if (r_last) begin
              r_sr <= '0;
            end
`endif
          end
        end
`ifdef CONV_ENC_TAIL_EN
        ST_TAIL0: begin
          if (sym_ready) begin
            r_sym_bit  <= r_c1;
            r_sym_last <= w_tcnt_done;
          end
        end
        ST_TAIL1: begin
          if (sym_ready) begin
            if (w_tcnt_done) begin
              r_sym_valid <= 1'b0;
              r_sym_last  <= 1'b0;
            end else begin
              r_sym_bit  <= w_c[1];
              r_c1       <= w_c[0];
              r_sr       <= {w_b, r_sr[K-2:1]};
              r_tcnt     <= r_tcnt + TW'(1);
              r_sym_last <= 1'b0;
            end
          end
        end
`endif
        default: begin
          r_sym_valid <= 1'b0;
          r_sym_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder. Expected symbols come from a direct
// convolution of the frame bits with the generator taps; follows the
// CONV_ENC_TAIL_EN build macro.
module tb_conv_encoder;

  localparam int unsigned K  = 7;
  localparam logic [6:0]  G0 = 7'o171;
  localparam logic [6:0]  G1 = 7'o133;
`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_bit, in_valid, in_last, in_ready;
  logic sym_bit, sym_valid, sym_ready, sym_last;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int viol_excl = 0;
  int viol_hold = 0;
  logic prev_stall = 1'b0, prev_bit = 1'b0, prev_last = 1'b0;

  logic [1:0] obs_q[$];
  logic [1:0] exp_q[$];

  conv_encoder #(.K(K), .G0(G0), .G1(G1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sym_bit   (sym_bit),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_last  (sym_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: convolve frame (plus zero tail) with generator taps
  function automatic void model_frame(input logic fr[$]);
    logic u[$];
    int unsigned len;
    u = fr;
    if (TAIL_EN) for (int unsigned t = 0; t < K - 1; t++) u.push_back(1'b0);
    len = u.size();
    for (int unsigned n = 0; n < len; n++) begin
      logic p0, p1;
      p0 = 1'b0;
      p1 = 1'b0;
      for (int unsigned j = 0; j < K && j <= n; j++) begin
        p0 ^= G0[K-1-j] & u[n-j];
        p1 ^= G1[K-1-j] & u[n-j];
      end
      exp_q.push_back({p0, 1'b0});
      exp_q.push_back({p1, logic'(n == len - 1)});
    end
  endfunction

  task automatic send_frame(input logic fr[$]);
    model_frame(fr);
    foreach (fr[i]) begin
      int n;
      in_bit   = fr[i];
      in_last  = (i == fr.size() - 1);
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) check_eq("in_timeout", 1, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_compare(input string tag);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check_eq({tag, "_timeout"}, 1, 0);
    repeat (6) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("%s_sym%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  // Symbol ready generator: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    sym_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = logic'($urandom_range(0, 1));
        default: sym_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor: record handshakes, watch hold and ready/valid exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready == sym_valid) viol_excl <= viol_excl + 1;
      if (prev_stall && (!sym_valid || sym_bit !== prev_bit || sym_last !== prev_last))
        viol_hold <= viol_hold + 1;
      if (sym_valid && sym_ready) obs_q.push_back({sym_bit, sym_last});
      prev_stall <= sym_valid && !sym_ready;
      prev_bit   <= sym_bit;
      prev_last  <= sym_last;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    logic fr[$];
    logic [13:0] pk;
    int n;
    int unsigned rst_at;

    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_sym_valid", sym_valid, 0);
    check_eq("rst_sym_bit", sym_bit, 0);
    check_eq("rst_sym_last", sym_last, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Impulse
    ready_mode = 0;
    @(posedge clk); #1;
    fr = {1'b1};
    send_frame(fr);
    drain_compare("impulse");
    pk = '0;
    foreach (obs_q[i]) pk = {pk[12:0], obs_q[i][1]};
    check_eq("impulse_bits", pk, TAIL_EN ? 14'b11101111000111 : 14'b11);
    clear_q();

    // All-zero frame of 8 bits
    fr.delete();
    repeat (8) fr.push_back(1'b0);
    send_frame(fr);
    drain_compare("zeros");
    check_eq("zeros_len", obs_q.size(), TAIL_EN ? 28 : 16);
    clear_q();

    // Frame 1,1 then frame 1
    fr = {1'b1, 1'b1};
    send_frame(fr);
    drain_compare("f11");
    pk = '0;
    for (int i = 0; i < 4; i++) pk = {pk[12:0], obs_q[i][1]};
    check_eq("f11_bits", pk, 14'b1101);
    clear_q();
    fr = {1'b1};
    send_frame(fr);
    drain_compare("f1");
    clear_q();

    // Backpressure on c0 of a bit 1 from state zero
    ready_mode = 2;
    @(posedge clk); #1;
    sym_ready = 1'b0;
    send_frame(fr);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_valid", sym_valid, 1);
      check_eq("bp_bit", sym_bit, 1);
      check_eq("bp_in_ready", in_ready, 0);
    end
    ready_mode = 0;
    drain_compare("bp");
    clear_q();

    // Reset mid-frame (tail symbol 3 when tail is built in)
    fr = {1'b1, 1'b1};
    rst_at = TAIL_EN ? 7 : 3;
    exp_q.delete();
    send_frame(fr);
    n = 0;
    while (obs_q.size() < rst_at && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check_eq("rst_wait_timeout", 1, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_sym_valid", sym_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    fr = {1'b1};
    send_frame(fr);
    drain_compare("postrst");
    check_eq("postrst_first", {obs_q[0][1], obs_q[1][1]}, 2'b11);
    clear_q();

    // Back-to-back random frames, in_valid held, random backpressure
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      fr.delete();
      repeat ((f == 0) ? 36 : $urandom_range(1, 10)) fr.push_back(logic'($urandom_range(0, 1)));
      send_frame(fr);
    end
    drain_compare("b2b");
    clear_q();
    ready_mode = 0;
    repeat (2) @(posedge clk);

    check_eq("ready_valid_excl", viol_excl, 0);
    check_eq("stall_hold", viol_hold, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
